// File: rtl/lop_share_arbiter_if.sv
// Requester-side bus of the shared LOP arbiter: request handshake plus the
// one-hot result strobe that routes each LOP result back to its issuer.
interface lop_share_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOP  = 5
);
  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ*SIZE_DATA-1:0] i_req_addr;
  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic [NUM_REQ-1:0]           o_rsp_valid;
  logic [ID_W-1:0]              o_rsp_id;
  logic [SIZE_DATA-1:0]         o_rsp_addr;
  logic [SIZE_LOP-1:0]          o_rsp_one_position;
  logic                         o_rsp_zero_flag;

  // requesters drive the request fields and observe grant/result
  modport master (
    output i_req_valid, i_req_addr, i_req_data,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_addr,
           o_rsp_one_position, o_rsp_zero_flag
  );

  // the arbiter consumes requests and produces grant/result
  modport slave (
    input  i_req_valid, i_req_addr, i_req_data,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_addr,
           o_rsp_one_position, o_rsp_zero_flag
  );
endinterface

// File: rtl/lop_share_arbiter.sv
// Round-robin sharing of one registered leading-one-position unit between
// NUM_REQ requesters. An {valid,id} tag rides a shift pipeline matched to the
// unit latency so each result is strobed back to the requester that issued it.
module lop_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOP  = 5,
  parameter int LOP_LAT   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  lop_share_arbiter_if.slave   bus,
  output logic                 o_lop_rst_n,
  output logic [SIZE_DATA-1:0] o_lop_addr,
  output logic [SIZE_DATA-1:0] o_lop_data,
  input  logic [SIZE_DATA-1:0] i_lop_addr,
  input  logic [SIZE_LOP-1:0]  i_lop_one_position,
  input  logic                 i_lop_zero_flag,
  output logic                 o_busy
);

  // [LOP_LAT-1:0] are the tag stages, [LOP_LAT] is the response stage
  logic [LOP_LAT:0]               r_vld_pipe;
  logic [LOP_LAT-1:0][ID_W-1:0]   r_id_pipe;
  logic [ID_W-1:0]                r_rr_ptr;
  logic [SIZE_DATA-1:0]           r_last_addr;
  logic [ID_W-1:0]                r_rsp_id;
  logic [SIZE_DATA-1:0]           r_rsp_addr;
  logic [SIZE_LOP-1:0]            r_rsp_pos;
  logic                           r_rsp_zf;

  logic [NUM_REQ-1:0][SIZE_DATA-1:0] w_addr;
  logic [NUM_REQ-1:0][SIZE_DATA-1:0] w_data;
  logic [NUM_REQ-1:0]             w_rot;
  logic                           w_found;
  int                             w_sum;
  logic [ID_W-1:0]                w_gnt_id;
  logic                           w_hs;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_addr[k] = bus.i_req_addr[k*SIZE_DATA +: SIZE_DATA];
    assign w_data[k] = bus.i_req_data[k*SIZE_DATA +: SIZE_DATA];
  end

  // valid bits rotated so bit 0 is the requester at the round-robin pointer
  assign w_rot = NUM_REQ'({bus.i_req_valid, bus.i_req_valid} >> r_rr_ptr);

  // first requested offset from the pointer, mapped back to an absolute id
  always_comb begin
    w_found = 1'b0;
    w_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = int'(r_rr_ptr) + k;
      end
    end
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
    w_gnt_id = ID_W'(w_sum);
  end

  // reset suppresses the grant so nothing issued during reset is tagged
  assign w_hs            = w_found & ~i_rst;
  assign bus.o_req_ready = w_hs ? (NUM_REQ'(1) << w_gnt_id) : '0;

  // idle cycles keep the unit's address steady; its output is not tagged anyway
  assign o_lop_addr  = i_rst ? '0 : (w_hs ? w_addr[w_gnt_id] : r_last_addr);
  assign o_lop_data  = w_hs ? w_data[w_gnt_id] : '0;
  assign o_lop_rst_n = ~i_rst;

  // pointer advance, last issued address and tag shift pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_last_addr <= '0;
      r_vld_pipe  <= '0;
      r_id_pipe   <= '0;
    end else begin
      if (w_hs) begin
        r_rr_ptr    <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        r_last_addr <= w_addr[w_gnt_id];
      end
      r_vld_pipe   <= {r_vld_pipe[LOP_LAT-1:0], w_hs};
      r_id_pipe[0] <= w_gnt_id;
      for (int s = 1; s < LOP_LAT; s++) r_id_pipe[s] <= r_id_pipe[s-1];
    end
  end

  // capture the unit's result when the final tag stage lines up with it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_id   <= '0;
      r_rsp_addr <= '0;
      r_rsp_pos  <= '0;
      r_rsp_zf   <= 1'b0;
    end else if (r_vld_pipe[LOP_LAT-1]) begin
      r_rsp_id   <= r_id_pipe[LOP_LAT-1];
      r_rsp_addr <= i_lop_addr;
      r_rsp_pos  <= i_lop_one_position;
      r_rsp_zf   <= i_lop_zero_flag;
    end
  end

  assign bus.o_rsp_valid        = r_vld_pipe[LOP_LAT] ? (NUM_REQ'(1) << r_rsp_id) : '0;
  assign bus.o_rsp_id           = r_rsp_id;
  assign bus.o_rsp_addr         = r_rsp_addr;
  assign bus.o_rsp_one_position = r_rsp_pos;
  assign bus.o_rsp_zero_flag    = r_rsp_zf;
  assign o_busy                 = |r_vld_pipe;

endmodule

// File: tb/tb_lop_share_arbiter.sv
// Bench for lop_share_arbiter: stand-in registered LOP unit, a queue-based
// reference model checked every cycle, directed cases and random traffic.
module tb_lop_share_arbiter;
  localparam int NUM_REQ = 4, ID_W = 2, SD = 24, SL = 5, LOP_LAT = 1;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  lop_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .SIZE_DATA(SD), .SIZE_LOP(SL)) bus ();

  logic          lop_rst_n, busy;
  logic [SD-1:0] lop_addr, lop_data, u_addr_o;
  logic [SL-1:0] u_pos_o;
  logic          u_zf_o;

  lop_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .SIZE_DATA(SD), .SIZE_LOP(SL),
                      .LOP_LAT(LOP_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_lop_rst_n(lop_rst_n),
    .o_lop_addr(lop_addr), .o_lop_data(lop_data), .i_lop_addr(u_addr_o),
    .i_lop_one_position(u_pos_o), .i_lop_zero_flag(u_zf_o), .o_busy(busy));

  function automatic int lead_one(input logic [SD-1:0] d);
    int p = 0;
    for (int i = 0; i < SD; i++) if (d[i]) p = i;
    return p;
  endfunction

  // stand-in LOP unit: LOP_LAT registered stages
  logic [SD-1:0] u_addr [LOP_LAT];
  logic [SL-1:0] u_pos  [LOP_LAT];
  logic          u_zf   [LOP_LAT];
  always @(posedge clk) begin
    if (!lop_rst_n) begin
      for (int s = 0; s < LOP_LAT; s++) begin u_addr[s] <= '0; u_pos[s] <= '0; u_zf[s] <= 1'b0; end
    end else begin
      u_addr[0] <= lop_addr;
      u_pos[0]  <= SL'(lead_one(lop_data));
      u_zf[0]   <= (lop_data == '0);
      for (int s = 1; s < LOP_LAT; s++) begin
        u_addr[s] <= u_addr[s-1]; u_pos[s] <= u_pos[s-1]; u_zf[s] <= u_zf[s-1];
      end
    end
  end
  assign u_addr_o = u_addr[LOP_LAT-1];
  assign u_pos_o  = u_pos[LOP_LAT-1];
  assign u_zf_o   = u_zf[LOP_LAT-1];

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model state
  typedef struct { int id; logic [SD-1:0] addr; int pos; bit zf; int due; } exp_t;
  exp_t q[$];
  int   cyc = 0, m_rr = 0;
  bit   armed = 0;
  logic [SD-1:0] m_last_issue = '0, m_raddr = '0;
  int   m_rpos = 0;
  bit   m_rzf = 0;
  logic [NUM_REQ-1:0] m_hs = '0;
  int   waits [NUM_REQ];
  int   rsp_cnt [NUM_REQ];
  initial for (int r = 0; r < NUM_REQ; r++) begin waits[r] = 0; rsp_cnt[r] = 0; end

  // compare process: every negedge, check DUT against the model, then advance it
  always @(negedge clk) begin
    exp_t e;
    int   g;
    logic [SD-1:0] ga, gd;
    cyc++;
    if (armed) begin
      chk("busy", 32'(busy), 32'(q.size() != 0));
      for (int r = 0; r < NUM_REQ; r++) if (bus.o_rsp_valid[r]) rsp_cnt[r]++;
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(1) << e.id);
        chk("rsp_id",    32'(bus.o_rsp_id), 32'(e.id));
        chk("rsp_addr",  32'(bus.o_rsp_addr), 32'(e.addr));
        chk("rsp_pos",   32'(bus.o_rsp_one_position), 32'(e.pos));
        chk("rsp_zf",    32'(bus.o_rsp_zero_flag), 32'(e.zf));
        m_raddr = e.addr; m_rpos = e.pos; m_rzf = e.zf;
      end else begin
        chk("rsp_idle",      32'(bus.o_rsp_valid), 32'd0);
        chk("rsp_hold_addr", 32'(bus.o_rsp_addr), 32'(m_raddr));
        chk("rsp_hold_pos",  32'(bus.o_rsp_one_position), 32'(m_rpos));
        chk("rsp_hold_zf",   32'(bus.o_rsp_zero_flag), 32'(m_rzf));
      end
      g = -1;
      if (!rst)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && bus.i_req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
      m_hs = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
      chk("grant", 32'(bus.o_req_ready), 32'(m_hs));
      if (g >= 0) begin
        ga = bus.i_req_addr[g*SD +: SD];
        gd = bus.i_req_data[g*SD +: SD];
        chk("lop_addr", 32'(lop_addr), 32'(ga));
        chk("lop_data", 32'(lop_data), 32'(gd));
        q.push_back('{id: g, addr: ga, pos: lead_one(gd), zf: (gd == '0), due: cyc + LOP_LAT + 1});
        total++;
        if (waits[g] > NUM_REQ - 1) begin
          bad++;
          $display("FAIL fairness: requester %0d waited %0d grants, limit %0d", g, waits[g], NUM_REQ - 1);
        end
        waits[g] = 0;
        for (int r = 0; r < NUM_REQ; r++) if (r != g && bus.i_req_valid[r]) waits[r]++;
        m_rr = (g + 1) % NUM_REQ;
        m_last_issue = ga;
      end else begin
        chk("lop_data_idle", 32'(lop_data), 32'd0);
        chk("lop_addr_idle", 32'(lop_addr), rst ? 32'd0 : 32'(m_last_issue));
      end
    end
    if (rst) begin
      q.delete(); m_rr = 0; m_last_issue = '0; m_raddr = '0; m_rpos = 0; m_rzf = 0;
      m_hs = '0; armed = 1;
      for (int r = 0; r < NUM_REQ; r++) waits[r] = 0;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic set_req(input int r, input logic [SD-1:0] a, input logic [SD-1:0] d);
    bus.i_req_addr[r*SD +: SD] = a;
    bus.i_req_data[r*SD +: SD] = d;
  endtask

  int c0 [NUM_REQ];
  int tot0;

  initial begin
    bus.i_req_valid = '0; bus.i_req_addr = '0; bus.i_req_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ready",  32'(bus.o_req_ready), 32'd0);
    chk("reset_busy",   32'(busy), 32'd0);
    chk("reset_rsp",    32'(bus.o_rsp_valid), 32'd0);
    chk("reset_rspid",  32'(bus.o_rsp_id), 32'd0);
    chk("reset_laddr",  32'(lop_addr), 32'd0);
    chk("reset_ldata",  32'(lop_data), 32'd0);
    chk("reset_lrstn",  32'(lop_rst_n), 32'd0);
    tick(); rst = 1'b0;

    // single request from requester 1
    set_req(1, 24'h000001, 24'h000100); bus.i_req_valid = 4'b0010;
    @(negedge clk); chk("t1_ready", 32'(bus.o_req_ready), 32'b0010);
    tick(); bus.i_req_valid = '0;
    tick(); @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.o_rsp_valid), 32'b0010);
    chk("t1_rsp_id",    32'(bus.o_rsp_id), 32'd1);
    chk("t1_rsp_addr",  32'(bus.o_rsp_addr), 32'h000001);
    chk("t1_rsp_pos",   32'(bus.o_rsp_one_position), 32'd8);
    chk("t1_rsp_zf",    32'(bus.o_rsp_zero_flag), 32'd0);

    // zero data from requester 2
    tick(); set_req(2, 24'h123456, 24'h0); bus.i_req_valid = 4'b0100;
    @(negedge clk); chk("t3_ready", 32'(bus.o_req_ready), 32'b0100);
    tick(); bus.i_req_valid = '0;
    tick(); @(negedge clk);
    chk("t3_rsp_valid", 32'(bus.o_rsp_valid), 32'b0100);
    chk("t3_rsp_zf",    32'(bus.o_rsp_zero_flag), 32'd1);

    // all four valid for 8 cycles from pointer 0
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      set_req(r, SD'(24'hA00000 + r), SD'(24'h10 << r)); c0[r] = rsp_cnt[r];
    end
    bus.i_req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("t2_order", 32'(bus.o_req_ready), 32'(1) << (i % 4));
      tick();
    end
    bus.i_req_valid = '0;
    repeat (4) tick();
    for (int r = 0; r < NUM_REQ; r++) chk("t2_rsp_count", 32'(rsp_cnt[r] - c0[r]), 32'd2);

    // requester 3 alone, one-hot data sweep
    c0[3] = rsp_cnt[3];
    bus.i_req_valid = 4'b1000;
    for (int k = 0; k < SD; k++) begin
      set_req(3, SD'(k), SD'(1) << k);
      @(negedge clk); chk("t4_ready", 32'(bus.o_req_ready), 32'b1000);
      tick();
    end
    bus.i_req_valid = '0;
    repeat (4) tick();
    chk("t4_rsp_count", 32'(rsp_cnt[3] - c0[3]), 32'd24);

    // reset with tags in flight
    rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < 3; r++) set_req(r, SD'(24'h0B0000 + r), SD'(24'h800 >> r));
    bus.i_req_valid = 4'b0111;
    repeat (3) begin @(negedge clk); tick(); bus.i_req_valid = bus.i_req_valid & ~m_hs; end
    tot0 = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    rst = 1'b1; tick(); rst = 1'b0;
    tot0 = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    @(negedge clk);
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    chk("t5_rsp_after_rst",  32'(bus.o_rsp_valid), 32'd0);
    repeat (3) tick();
    chk("t5_no_late_rsp", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] - tot0), 32'd0);
    bus.i_req_valid = 4'b1111;
    @(negedge clk); chk("t5_rr_zero", 32'(bus.o_req_ready), 32'b0001);
    tick(); bus.i_req_valid = '0;
    repeat (3) tick();

    // random traffic, requesters hold fields until granted
    for (int c = 0; c < 1000; c++) begin
      bus.i_req_valid = bus.i_req_valid & ~m_hs;
      for (int r = 0; r < NUM_REQ; r++)
        if (!bus.i_req_valid[r] && ($urandom % 2 == 0)) begin
          set_req(r, SD'($urandom), ($urandom % 8 == 0) ? '0 : SD'($urandom) >> $urandom_range(0, SD - 1));
          bus.i_req_valid[r] = 1'b1;
        end
      @(negedge clk);
      tick();
    end
    bus.i_req_valid = '0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
